// File: rtl/button_gesture_decoder.sv
// -----------------------------------------------------------------------------
// button_gesture_decoder
//
// Turns the debounced press/release pulses of one button into user gestures:
// single click, double click, long press and, optionally, auto-repeat while the
// button stays held after a long press. One instance per physical button.
//
// Optional feature macro:
//   BUTTON_GESTURE_REPEAT_EN  - when defined, repeat_pulse ticks every
//                               REPEAT_CYCLES cycles while in the long-held
//                               state; when undefined, repeat_pulse is tied 0.
//
// Parameters:
//   CNT_W          width of the shared timing counter
//   DBL_CYCLES     double-click window measured from the first release
//   LONG_CYCLES    hold time that qualifies as a long press
//   REPEAT_CYCLES  auto-repeat period (used only with BUTTON_GESTURE_REPEAT_EN)
//
// Ports:
//   clk           in   system clock
//   rst           in   synchronous active-high reset
//   btn_down      in   1-cycle pulse, debounced press
//   btn_up        in   1-cycle pulse, debounced release
//   click         out  1-cycle pulse, single click recognised
//   double_click  out  1-cycle pulse, double click recognised
//   long_press    out  1-cycle pulse, hold reached LONG_CYCLES
//   repeat_pulse  out  1-cycle pulse, auto-repeat tick
//   busy          out  level, a gesture is in progress
// -----------------------------------------------------------------------------
module button_gesture_decoder #(
  parameter int unsigned CNT_W         = 26,
  parameter int unsigned DBL_CYCLES    = 25_000_000,
  parameter int unsigned LONG_CYCLES   = 50_000_000,
  parameter int unsigned REPEAT_CYCLES = 10_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_down,
  input  logic btn_up,
  output logic click,
  output logic double_click,
  output logic long_press,
  output logic repeat_pulse,
  output logic busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    WAIT2  = 3'd2,
    PRESS2 = 3'd3,
    LONG   = 3'd4
  } state_t;

  // Elaboration-time sanity check of the timing parameters.
  localparam longint unsigned CNT_SPAN = 64'd1 << CNT_W;
  localparam bit CFG_OK =
      (DBL_CYCLES    >= 32'd2) && (64'(DBL_CYCLES)    < CNT_SPAN) &&
      (LONG_CYCLES   >= 32'd2) && (64'(LONG_CYCLES)   < CNT_SPAN) &&
      (REPEAT_CYCLES >= 32'd2) && (64'(REPEAT_CYCLES) < CNT_SPAN);

  if (!CFG_OK) begin : g_cfg_err
    $error("button_gesture_decoder: *_CYCLES must be >= 2 and < 2**CNT_W");
  end

  // The counter holds "cycles spent in this state minus one" at the edge where
  // the timeout fires, so the compare values are the period minus one.
  localparam logic [CNT_W-1:0] DBL_LAST  = CNT_W'(DBL_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(32'd1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};

  state_t           state_r;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nx;

  logic click_nx;
  logic double_nx;
  logic long_nx;
  logic busy_nx;
  logic repeat_tick;

  // Simultaneous press and release pulses cancel each other out.
  logic down_ev;
  logic up_ev;
  logic dbl_hit;
  logic long_hit;

  assign down_ev  = btn_down & ~btn_up;
  assign up_ev    = btn_up & ~btn_down;
  assign dbl_hit  = (cnt_r == DBL_LAST);
  assign long_hit = (cnt_r == LONG_LAST);

`ifdef BUTTON_GESTURE_REPEAT_EN
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 32'd1);
  logic repeat_r;

  // A release in the same cycle as a tick wins and suppresses the tick.
  assign repeat_tick = (state_r == LONG) && !up_ev && (cnt_r == REPEAT_LAST);
`else
  assign repeat_tick = 1'b0;
`endif

  // State register, timing counter and registered gesture outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      cnt_r        <= CNT_ZERO;
      click        <= 1'b0;
      double_click <= 1'b0;
      long_press   <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state_r      <= state_nx;
      cnt_r        <= cnt_nx;
      click        <= click_nx;
      double_click <= double_nx;
      long_press   <= long_nx;
      busy         <= busy_nx;
    end
  end

`ifdef BUTTON_GESTURE_REPEAT_EN
  // Auto-repeat output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      repeat_r <= 1'b0;
    end else begin
      repeat_r <= repeat_tick;
    end
  end

  assign repeat_pulse = repeat_r;
`else
  assign repeat_pulse = 1'b0;
`endif

  // Next-state logic; an input event always takes priority over a timeout.
  always_comb begin
    state_nx = state_r;
    case (state_r)
      IDLE: begin
        if (down_ev) state_nx = PRESS1;
        else         state_nx = IDLE;
      end
      PRESS1: begin
        if (up_ev)         state_nx = WAIT2;
        else if (long_hit) state_nx = LONG;
        else               state_nx = PRESS1;
      end
      WAIT2: begin
        if (down_ev)      state_nx = PRESS2;
        else if (dbl_hit) state_nx = IDLE;
        else              state_nx = WAIT2;
      end
      PRESS2: begin
        if (up_ev)         state_nx = IDLE;
        else if (long_hit) state_nx = LONG;
        else               state_nx = PRESS2;
      end
      LONG: begin
        if (up_ev) state_nx = IDLE;
        else       state_nx = LONG;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Counter: cleared on any state change or repeat tick, else saturating count.
  always_comb begin
    cnt_nx = cnt_r;
    if (state_nx != state_r) begin
      cnt_nx = CNT_ZERO;
    end else if (repeat_tick) begin
      cnt_nx = CNT_ZERO;
    end else if (cnt_r != CNT_MAX) begin
      cnt_nx = cnt_r + CNT_ONE;
    end else begin
      cnt_nx = cnt_r;
    end
  end

  // Output decode: next values of the registered gesture pulses.
  always_comb begin
    click_nx  = 1'b0;
    double_nx = 1'b0;
    long_nx   = 1'b0;
    busy_nx   = (state_nx != IDLE);
    case (state_r)
      IDLE: begin
        click_nx = 1'b0;
      end
      PRESS1: begin
        long_nx = !up_ev && long_hit;
      end
      WAIT2: begin
        click_nx = !down_ev && dbl_hit;
      end
      PRESS2: begin
        double_nx = up_ev;
        // A second press held long still counts the first tap as a click.
        click_nx  = !up_ev && long_hit;
        long_nx   = !up_ev && long_hit;
      end
      LONG: begin
        long_nx = 1'b0;
      end
      default: begin
        click_nx = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_button_gesture_decoder.sv
// -----------------------------------------------------------------------------
// tb_button_gesture_decoder
//
// Directed gesture scenarios followed by random press/release/reset traffic.
// Expected outputs come from a timestamp-based reference model: each pending
// timeout is the absolute cycle of the last qualifying event plus a period.
// -----------------------------------------------------------------------------
module tb_button_gesture_decoder;

  localparam int unsigned CNT_W = 4;
  localparam int unsigned DBL   = 4;
  localparam int unsigned LONGC = 8;
  localparam int unsigned REP   = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_down = 1'b0;
  logic btn_up = 1'b0;
  logic click, double_click, long_press, repeat_pulse, busy;

  int checks = 0;
  int errors = 0;

  // Reference model state: gesture phase plus absolute cycle of its start.
  localparam int G_NONE = 0, G_HELD1 = 1, G_GAP = 2, G_HELD2 = 3, G_HELDLONG = 4;
  int   phase = G_NONE;
  int   since = 0;
  int   cyc   = 0;
  logic e_click, e_double, e_long, e_repeat, e_busy;

  button_gesture_decoder #(
    .CNT_W(CNT_W), .DBL_CYCLES(DBL), .LONG_CYCLES(LONGC), .REPEAT_CYCLES(REP)
  ) dut (
    .clk(clk), .rst(rst), .btn_down(btn_down), .btn_up(btn_up),
    .click(click), .double_click(double_click), .long_press(long_press),
    .repeat_pulse(repeat_pulse), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic expd);
    checks++;
    assert (obs === expd) else begin
      errors++;
      $error("FAIL %s: observed %0b expected %0b at cycle %0d", tag, obs, expd, cyc);
    end
  endtask

  // Apply one clock edge's worth of rules to the model.
  task automatic model_edge(input logic d, input logic u, input logic r);
    logic press, release_;
    int   elapsed;
    e_click = 1'b0; e_double = 1'b0; e_long = 1'b0; e_repeat = 1'b0;
    press    = d && !u;
    release_ = u && !d;
    elapsed  = cyc - since;
    if (r) begin
      phase = G_NONE;
    end else begin
      case (phase)
        G_NONE: if (press) begin phase = G_HELD1; since = cyc; end
        G_HELD1: begin
          if (release_) begin phase = G_GAP; since = cyc; end
          else if (elapsed == LONGC) begin e_long = 1'b1; phase = G_HELDLONG; since = cyc; end
        end
        G_GAP: begin
          if (press) begin phase = G_HELD2; since = cyc; end
          else if (elapsed == DBL) begin e_click = 1'b1; phase = G_NONE; end
        end
        G_HELD2: begin
          if (release_) begin e_double = 1'b1; phase = G_NONE; end
          else if (elapsed == LONGC) begin
            e_click = 1'b1; e_long = 1'b1; phase = G_HELDLONG; since = cyc;
          end
        end
        G_HELDLONG: begin
          if (release_) phase = G_NONE;
`ifdef BUTTON_GESTURE_REPEAT_EN
          else if (elapsed == REP) begin e_repeat = 1'b1; since = cyc; end
`endif
        end
        default: phase = G_NONE;
      endcase
    end
    e_busy = (phase != G_NONE);
  endtask

  // Drive one cycle of inputs, clock it, then compare all outputs to the model.
  task automatic step(input logic d, input logic u, input logic r);
    btn_down = d; btn_up = u; rst = r;
    @(posedge clk);
    #1;
    model_edge(d, u, r);
    chk("click", click, e_click);
    chk("double_click", double_click, e_double);
    chk("long_press", long_press, e_long);
    chk("repeat_pulse", repeat_pulse, e_repeat);
    chk("busy", busy, e_busy);
    cyc++;
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_click", click, 1'b0);
    chk("rst_long", long_press, 1'b0);
    idle_steps(2);

    // 1: down@0, up@2 -> click at 6 only, busy low from 6
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    for (int c = 3; c < 10; c++) begin
      step(1'b0, 1'b0, 1'b0);
      chk("t1_click", click, (c == 6) ? 1'b1 : 1'b0);
      if (c >= 6) chk("t1_busy", busy, 1'b0);
    end

    // 2: down@0, up@2, down@4, up@5 -> double_click at 5
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    chk("t2_double", double_click, 1'b1);
    chk("t2_busy", busy, 1'b0);
    idle_steps(12);

    // 3 / 6: down@0 held, up@20 -> long_press at 8 (repeat at 11,14,17 if enabled)
    step(1'b1, 1'b0, 1'b0);
    for (int c = 1; c < 20; c++) begin
      step(1'b0, 1'b0, 1'b0);
      chk("t3_long", long_press, (c == 8) ? 1'b1 : 1'b0);
`ifdef BUTTON_GESTURE_REPEAT_EN
      chk("t6_repeat", repeat_pulse, (c == 11 || c == 14 || c == 17) ? 1'b1 : 1'b0);
`else
      chk("t3_repeat", repeat_pulse, 1'b0);
`endif
    end
    step(1'b0, 1'b1, 1'b0);
    chk("t3_busy20", busy, 1'b0);
    chk("t3_rep20", repeat_pulse, 1'b0);
    idle_steps(6);

    // 4: down@0, up@1, down@3, held -> click and long_press at 11
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    for (int c = 4; c < 13; c++) begin
      step(1'b0, 1'b0, 1'b0);
      chk("t4_click", click, (c == 11) ? 1'b1 : 1'b0);
      chk("t4_long", long_press, (c == 11) ? 1'b1 : 1'b0);
    end
    step(1'b0, 1'b1, 1'b0);
    idle_steps(3);

    // 5: down@0, up@2, rst@4 -> silent abort, down@6 starts fresh
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    chk("t5_busy4", busy, 1'b0);
    chk("t5_click4", click, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("t5_click5", click, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk("t5_busy6", busy, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    idle_steps(8);

    // Same-cycle press and release is ignored.
    step(1'b1, 1'b1, 1'b0);
    chk("both_ignored", busy, 1'b0);
    idle_steps(2);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
